seq_alu: RTL and testbench
==========================

Name: seq_alu

Overview:
- Parametrised, registered successor to the datapath ALU. Data width is generic and operands arrive over a valid/ready handshake.
- Multiply and divide are iterative multi-cycle operations; all other ops complete in one cycle.
- Produces a full flag set and a high-word result (product high half / remainder). Sits between the register-file read stage and write-back; the pipeline stalls on InReady/OutValid.

Parameters:
- WIDTH, 32, operand/result width in bits (>=4, power of 2).
- SIGNED_SLT, 0, 1 = set-less-than compares signed, 0 = unsigned.

Ports:
- Clk  in  1  rising-edge clock
- Rst_n  in  1  asynchronous active-low reset
- InValid  in  1  operand/opcode valid
- InReady  out  1  block can accept an operation
- OP1  in  WIDTH  operand 1
- OP2  in  WIDTH  operand 2
- Sel  in  3  opcode
- OutValid  out  1  Result/flags valid
- OutReady  in  1  consumer accepts result
- Result  out  WIDTH  primary result
- ResultHi  out  WIDTH  mul: product[2W-1:W]; div: remainder; else 0
- ZeroFlag  out  1  1 when Result == 0
- NegFlag  out  1  Result[WIDTH-1]
- CarryFlag  out  1  add: carry-out; sub: borrow (OP1<OP2 unsigned); else 0
- OvfFlag  out  1  signed overflow for add/sub; else 0
- DivZeroFlag  out  1  div with OP2 == 0

Behaviour:
- Opcodes (Sel):
  - 000 add, 001 sub (OP1-OP2), 010 slt (Result = 1/0)
  - 011 mul (unsigned), 100 div (unsigned, quotient)
  - 101 and, 110 or
  - 111 shl: OP1 << OP2[log2(WIDTH)-1:0]
- Reset (async, Rst_n=0): state IDLE; InReady=0 during reset and 1 after; OutValid=0; Result, ResultHi and all flags = 0; iteration counter = 0. Reset mid-operation aborts it and no result is produced.
- States:
  - IDLE: InReady=1, OutValid=0. On InValid at a rising edge, OP1/OP2/Sel are captured; later input changes are ignored.
    - Single-cycle ops and div with OP2==0 -> DONE.
    - mul -> MUL; div with OP2!=0 -> DIV. Counter loads WIDTH.
  - MUL: shift-add, one multiplier bit per cycle; counter decrements; when counter reaches 0 -> DONE.
  - DIV: restoring division, one quotient bit per cycle; same counter rule -> DONE.
  - DONE: OutValid=1; outputs held stable. On OutReady -> IDLE. InReady=0 in MUL/DIV/DONE; there is no same-cycle accept of a new op while in DONE.
- Latency, counted from the accept edge:
  - Single-cycle ops: OutValid after the next edge (1 cycle).
  - mul/div: OutValid after WIDTH+1 edges.
  - Throughput: one op per 2 cycles minimum.
- Arithmetic:
  - add/sub computed WIDTH+1 wide; bit WIDTH gives the carry/borrow.
  - Ovf(add) = sign(OP1)==sign(OP2) and sign(Result)!=sign(OP1).
  - Ovf(sub) = sign(OP1)!=sign(OP2) and sign(Result)!=sign(OP1).
  - Shift amount >= WIDTH cannot occur (amount is truncated to log2(WIDTH) bits).
- Divide by zero: Result = all ones, ResultHi = OP1, DivZeroFlag=1, single-cycle latency.
- Flags are registered together with Result and are valid only while OutValid=1. DivZeroFlag=0 for every other op.
- OutReady while OutValid=0 is ignored. InValid outside IDLE is ignored: the producer must hold it until InReady.

Test Plan (WIDTH=32):
- Reset: hold Rst_n=0 during a mul, release -> OutValid=0, InReady=1, all outputs 0, and no stale result ever appears.
- Add: 0xFFFFFFFF+1 -> Result=0, Zero=1, Carry=1, Ovf=0, after exactly 1 cycle. Then 0x7FFFFFFF+1 -> 0x80000000, Neg=1, Ovf=1.
- Sub/slt: 3-5 -> 0xFFFFFFFE, Carry(borrow)=1. slt 0xFFFFFFFF,1 -> 0 with SIGNED_SLT=0 and 1 with SIGNED_SLT=1.
- Mul: 0xFFFFFFFF*0xFFFFFFFF -> Result=0x00000001, ResultHi=0xFFFFFFFE, OutValid exactly 33 cycles after accept. Toggle OP1 mid-op -> result unchanged.
- Div: 100/7 -> Result=14, ResultHi=2 after 33 cycles. Then 5/0 -> Result=0xFFFFFFFF, ResultHi=5, DivZero=1 after 1 cycle.
- Backpressure: hold OutReady=0 for 10 cycles in DONE -> outputs stable, InReady=0, InValid ignored. Raise OutReady -> IDLE next edge, new op accepted.

Source files
------------

// File: rtl/seq_alu.sv
// seq_alu: registered ALU with valid/ready handshake on both sides.
// Add/sub/slt/and/or/shl and divide-by-zero finish on the accept edge.
// Multiply (shift-add) and divide (restoring) retire one bit per cycle.
// The ports keep their fixed upstream names (Clk, Rst_n, OP1, ...).
module seq_alu #(
  parameter int unsigned WIDTH      = 32,
  parameter bit          SIGNED_SLT = 1'b0
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             InValid,
  output logic             InReady,
  input  logic [WIDTH-1:0] OP1,
  input  logic [WIDTH-1:0] OP2,
  input  logic [2:0]       Sel,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [WIDTH-1:0] Result,
  output logic [WIDTH-1:0] ResultHi,
  output logic             ZeroFlag,
  output logic             NegFlag,
  output logic             CarryFlag,
  output logic             OvfFlag,
  output logic             DivZeroFlag
);

  localparam int unsigned SW = $clog2(WIDTH);
  localparam int unsigned CW = SW + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_SLT = 3'b010;
  localparam logic [2:0] OP_MUL = 3'b011;
  localparam logic [2:0] OP_DIV = 3'b100;
  localparam logic [2:0] OP_AND = 3'b101;
  localparam logic [2:0] OP_OR  = 3'b110;
  localparam logic [2:0] OP_SHL = 3'b111;

  // Architectural state
  logic [1:0]       r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_opnd;   // mul: multiplicand, div: divisor
  logic [WIDTH-1:0] r_acc;    // mul: product high, div: partial remainder
  logic [WIDTH-1:0] r_mq;     // mul: multiplier/product low, div: dividend/quotient
  logic             r_in_ready;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_result;
  logic [WIDTH-1:0] r_result_hi;
  logic             r_zero;
  logic             r_neg;
  logic             r_carry;
  logic             r_ovf;
  logic             r_divz;

  // Next-state values
  logic [1:0]       w_state_nxt;
  logic [CW-1:0]    w_cnt_nxt;
  logic [WIDTH-1:0] w_opnd_nxt;
  logic [WIDTH-1:0] w_acc_nxt;
  logic [WIDTH-1:0] w_mq_nxt;
  logic             w_in_ready_nxt;
  logic             w_out_valid_nxt;
  logic [WIDTH-1:0] w_result_nxt;
  logic [WIDTH-1:0] w_result_hi_nxt;
  logic             w_zero_nxt;
  logic             w_neg_nxt;
  logic             w_carry_nxt;
  logic             w_ovf_nxt;
  logic             w_divz_nxt;
  logic             w_load;

  // Single-cycle datapath
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_diff;
  logic             w_slt;
  logic [WIDTH-1:0] w_shl;
  logic [WIDTH-1:0] w_sc_result;
  logic [WIDTH-1:0] w_sc_hi;
  logic             w_sc_carry;
  logic             w_sc_ovf;
  logic             w_sc_divz;

  // Iterative datapath
  logic [WIDTH:0]   w_mul_add;
  logic [WIDTH-1:0] w_mul_acc_nxt;
  logic [WIDTH-1:0] w_mul_mq_nxt;
  logic [WIDTH:0]   w_div_shift;
  logic [WIDTH:0]   w_div_sub;
  logic             w_div_ok;
  logic [WIDTH-1:0] w_div_rem_nxt;
  logic [WIDTH-1:0] w_div_quo_nxt;

  // Extended-width add/sub so bit WIDTH carries the carry-out or borrow
  assign w_sum  = {1'b0, OP1} + {1'b0, OP2};
  assign w_diff = {1'b0, OP1} - {1'b0, OP2};
  assign w_slt  = SIGNED_SLT ? ($signed(OP1) < $signed(OP2)) : (OP1 < OP2);
  assign w_shl  = OP1 << OP2[SW-1:0];

  // One shift-add step: add multiplicand when the multiplier LSB is set, then shift right
  assign w_mul_add     = {1'b0, r_acc} + (r_mq[0] ? {1'b0, r_opnd} : {(WIDTH+1){1'b0}});
  assign w_mul_acc_nxt = w_mul_add[WIDTH:1];
  assign w_mul_mq_nxt  = {w_mul_add[0], r_mq[WIDTH-1:1]};

  // One restoring-division step: shift in next dividend bit, keep difference if no borrow
  assign w_div_shift   = {r_acc, r_mq[WIDTH-1]};
  assign w_div_sub     = w_div_shift - {1'b0, r_opnd};
  assign w_div_ok      = ~w_div_sub[WIDTH];
  assign w_div_rem_nxt = w_div_ok ? w_div_sub[WIDTH-1:0] : w_div_shift[WIDTH-1:0];
  assign w_div_quo_nxt = {r_mq[WIDTH-2:0], w_div_ok};

  // Results of ops that finish on the accept edge
  always_comb begin
    w_sc_result = '0;
    w_sc_hi     = '0;
    w_sc_carry  = 1'b0;
    w_sc_ovf    = 1'b0;
    w_sc_divz   = 1'b0;
    case (Sel)
      OP_ADD: begin
        w_sc_result = w_sum[WIDTH-1:0];
        w_sc_carry  = w_sum[WIDTH];
        w_sc_ovf    = (OP1[WIDTH-1] == OP2[WIDTH-1]) && (w_sum[WIDTH-1] != OP1[WIDTH-1]);
      end
      OP_SUB: begin
        w_sc_result = w_diff[WIDTH-1:0];
        w_sc_carry  = w_diff[WIDTH];
        w_sc_ovf    = (OP1[WIDTH-1] != OP2[WIDTH-1]) && (w_diff[WIDTH-1] != OP1[WIDTH-1]);
      end
      OP_SLT: w_sc_result = WIDTH'(w_slt);
      OP_DIV: begin
        // only reached with a zero divisor
        w_sc_result = '1;
        w_sc_hi     = OP1;
        w_sc_divz   = 1'b1;
      end
      OP_AND: w_sc_result = OP1 & OP2;
      OP_OR:  w_sc_result = OP1 | OP2;
      OP_SHL: w_sc_result = w_shl;
      default: ;
    endcase
  end

  // Next-state and next-output logic
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_opnd_nxt      = r_opnd;
    w_acc_nxt       = r_acc;
    w_mq_nxt        = r_mq;
    w_result_nxt    = r_result;
    w_result_hi_nxt = r_result_hi;
    w_carry_nxt     = r_carry;
    w_ovf_nxt       = r_ovf;
    w_divz_nxt      = r_divz;
    w_zero_nxt      = r_zero;
    w_neg_nxt       = r_neg;
    w_load          = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (r_in_ready && InValid) begin
          if (Sel == OP_MUL) begin
            w_state_nxt = S_MUL;
            w_cnt_nxt   = CW'(WIDTH);
            w_opnd_nxt  = OP1;
            w_mq_nxt    = OP2;
            w_acc_nxt   = '0;
          end else if ((Sel == OP_DIV) && (OP2 != '0)) begin
            w_state_nxt = S_DIV;
            w_cnt_nxt   = CW'(WIDTH);
            w_opnd_nxt  = OP2;
            w_mq_nxt    = OP1;
            w_acc_nxt   = '0;
          end else begin
            w_state_nxt     = S_DONE;
            w_load          = 1'b1;
            w_result_nxt    = w_sc_result;
            w_result_hi_nxt = w_sc_hi;
            w_carry_nxt     = w_sc_carry;
            w_ovf_nxt       = w_sc_ovf;
            w_divz_nxt      = w_sc_divz;
          end
        end
      end
      S_MUL: begin
        w_acc_nxt = w_mul_acc_nxt;
        w_mq_nxt  = w_mul_mq_nxt;
        w_cnt_nxt = r_cnt - CW'(1);
        if (r_cnt == CW'(1)) begin
          w_state_nxt     = S_DONE;
          w_load          = 1'b1;
          w_result_nxt    = w_mul_mq_nxt;
          w_result_hi_nxt = w_mul_acc_nxt;
          w_carry_nxt     = 1'b0;
          w_ovf_nxt       = 1'b0;
          w_divz_nxt      = 1'b0;
        end
      end
      S_DIV: begin
        w_acc_nxt = w_div_rem_nxt;
        w_mq_nxt  = w_div_quo_nxt;
        w_cnt_nxt = r_cnt - CW'(1);
        if (r_cnt == CW'(1)) begin
          w_state_nxt     = S_DONE;
          w_load          = 1'b1;
          w_result_nxt    = w_div_quo_nxt;
          w_result_hi_nxt = w_div_rem_nxt;
          w_carry_nxt     = 1'b0;
          w_ovf_nxt       = 1'b0;
          w_divz_nxt      = 1'b0;
        end
      end
      S_DONE: begin
        if (OutReady) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    if (w_load) begin
      w_zero_nxt = (w_result_nxt == '0);
      w_neg_nxt  = w_result_nxt[WIDTH-1];
    end

    w_in_ready_nxt  = (w_state_nxt == S_IDLE);
    w_out_valid_nxt = (w_state_nxt == S_DONE);
  end

  // State and output registers; reset aborts any operation in flight
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_opnd      <= '0;
      r_acc       <= '0;
      r_mq        <= '0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_result_hi <= '0;
      r_zero      <= 1'b0;
      r_neg       <= 1'b0;
      r_carry     <= 1'b0;
      r_ovf       <= 1'b0;
      r_divz      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_opnd      <= w_opnd_nxt;
      r_acc       <= w_acc_nxt;
      r_mq        <= w_mq_nxt;
      r_in_ready  <= w_in_ready_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_result    <= w_result_nxt;
      r_result_hi <= w_result_hi_nxt;
      r_zero      <= w_zero_nxt;
      r_neg       <= w_neg_nxt;
      r_carry     <= w_carry_nxt;
      r_ovf       <= w_ovf_nxt;
      r_divz      <= w_divz_nxt;
    end
  end

  assign InReady     = r_in_ready;
  assign OutValid    = r_out_valid;
  assign Result      = r_result;
  assign ResultHi    = r_result_hi;
  assign ZeroFlag    = r_zero;
  assign NegFlag     = r_neg;
  assign CarryFlag   = r_carry;
  assign OvfFlag     = r_ovf;
  assign DivZeroFlag = r_divz;

endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: directed vector table plus hand-written reset/backpressure sequences.
// Two instances share stimulus: dut_u (unsigned slt) and dut_s (signed slt).
// Latency = number of rising edges from the accept edge (inclusive) until OutValid is seen.
module tb_seq_alu;

  logic        Clk;
  logic        Rst_n;
  logic        InValid;
  logic [31:0] OP1;
  logic [31:0] OP2;
  logic [2:0]  Sel;
  logic        OutReady;

  logic        InReady, OutValid, ZeroFlag, NegFlag, CarryFlag, OvfFlag, DivZeroFlag;
  logic [31:0] Result, ResultHi;
  logic        s_in_ready, s_out_valid, s_zero, s_neg, s_carry, s_ovf, s_divz;
  logic [31:0] s_result, s_result_hi;

  int n_chk  = 0;
  int n_fail = 0;

  seq_alu #(.WIDTH(32), .SIGNED_SLT(1'b0)) dut_u (
    .Clk(Clk), .Rst_n(Rst_n), .InValid(InValid), .InReady(InReady),
    .OP1(OP1), .OP2(OP2), .Sel(Sel), .OutValid(OutValid), .OutReady(OutReady),
    .Result(Result), .ResultHi(ResultHi), .ZeroFlag(ZeroFlag), .NegFlag(NegFlag),
    .CarryFlag(CarryFlag), .OvfFlag(OvfFlag), .DivZeroFlag(DivZeroFlag)
  );

  seq_alu #(.WIDTH(32), .SIGNED_SLT(1'b1)) dut_s (
    .Clk(Clk), .Rst_n(Rst_n), .InValid(InValid), .InReady(s_in_ready),
    .OP1(OP1), .OP2(OP2), .Sel(Sel), .OutValid(s_out_valid), .OutReady(OutReady),
    .Result(s_result), .ResultHi(s_result_hi), .ZeroFlag(s_zero), .NegFlag(s_neg),
    .CarryFlag(s_carry), .OvfFlag(s_ovf), .DivZeroFlag(s_divz)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  sel;
    logic [31:0] res;
    logic [31:0] res_s;
    logic [31:0] hi;
    logic [4:0]  flags;   // {Zero, Neg, Carry, Ovf, DivZero}
    int          lat;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic [31:0] a, input logic [31:0] b, input logic [2:0] sel,
                              input logic [31:0] res, input logic [31:0] res_s,
                              input logic [31:0] hi, input logic [4:0] flags, input int lat);
    vec_t v;
    v.a = a; v.b = b; v.sel = sel; v.res = res; v.res_s = res_s;
    v.hi = hi; v.flags = flags; v.lat = lat;
    return v;
  endfunction

  function automatic logic [4:0] flags_u();
    return {ZeroFlag, NegFlag, CarryFlag, OvfFlag, DivZeroFlag};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Present an op at a falling edge, wait for accept, scramble inputs, wait for OutValid.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [2:0] s,
                        output int lat);
    int guard;
    guard = 0;
    while (!InReady && guard < 50) begin
      @(negedge Clk);
      guard++;
    end
    OP1 = a; OP2 = b; Sel = s; InValid = 1'b1;
    @(posedge Clk);
    lat = 1;
    @(negedge Clk);
    InValid = 1'b0; OP1 = ~a; OP2 = ~b; Sel = ~s;
    while (!OutValid && lat < 100) begin
      OP1 = $urandom;
      @(posedge Clk);
      lat++;
      @(negedge Clk);
    end
  endtask

  task automatic release_result();
    OutReady = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    OutReady = 1'b0;
  endtask

  initial begin
    int lat;
    int stale;
    int unstable;
    int busy_ready;
    logic [31:0] snap_r, snap_h;
    logic [4:0]  snap_f;

    vecs.push_back(mk(32'hFFFFFFFF, 32'h00000001, 3'b000, 32'h00000000, 32'h00000000, 32'h0, 5'b10100, 1));
    vecs.push_back(mk(32'h7FFFFFFF, 32'h00000001, 3'b000, 32'h80000000, 32'h80000000, 32'h0, 5'b01010, 1));
    vecs.push_back(mk(32'h00000003, 32'h00000005, 3'b001, 32'hFFFFFFFE, 32'hFFFFFFFE, 32'h0, 5'b01100, 1));
    vecs.push_back(mk(32'h80000000, 32'h00000001, 3'b001, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h0, 5'b00010, 1));
    vecs.push_back(mk(32'hFFFFFFFF, 32'h00000001, 3'b010, 32'h00000000, 32'h00000001, 32'h0, 5'b10000, 1));
    vecs.push_back(mk(32'h00000001, 32'h00000002, 3'b010, 32'h00000001, 32'h00000001, 32'h0, 5'b00000, 1));
    vecs.push_back(mk(32'hFFFFFFFF, 32'hFFFFFFFF, 3'b011, 32'h00000001, 32'h00000001, 32'hFFFFFFFE, 5'b00000, 33));
    vecs.push_back(mk(32'h00010000, 32'h00010000, 3'b011, 32'h00000000, 32'h00000000, 32'h00000001, 5'b10000, 33));
    vecs.push_back(mk(32'd100,      32'd7,        3'b100, 32'd14,       32'd14,       32'd2,        5'b00000, 33));
    vecs.push_back(mk(32'd5,        32'd0,        3'b100, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd5,        5'b01001, 1));
    vecs.push_back(mk(32'd7,        32'd100,      3'b100, 32'd0,        32'd0,        32'd7,        5'b10000, 33));
    vecs.push_back(mk(32'hFFFFFFFF, 32'hFFFFFFFF, 3'b100, 32'd1,        32'd1,        32'd0,        5'b00000, 33));
    vecs.push_back(mk(32'hF0F0F0F0, 32'hFF00FF00, 3'b101, 32'hF000F000, 32'hF000F000, 32'h0, 5'b01000, 1));
    vecs.push_back(mk(32'h12340000, 32'h00005678, 3'b110, 32'h12345678, 32'h12345678, 32'h0, 5'b00000, 1));
    vecs.push_back(mk(32'h00000001, 32'd31,       3'b111, 32'h80000000, 32'h80000000, 32'h0, 5'b01000, 1));
    vecs.push_back(mk(32'h00000003, 32'h00000021, 3'b111, 32'h00000006, 32'h00000006, 32'h0, 5'b00000, 1));

    // Power-on reset
    Rst_n = 1'b0; InValid = 1'b0; OutReady = 1'b0; OP1 = '0; OP2 = '0; Sel = '0;
    repeat (3) @(negedge Clk);
    chk("rst_inready", 32'(InReady), 32'd0);
    chk("rst_outvalid", 32'(OutValid), 32'd0);
    Rst_n = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    chk("post_rst_inready", 32'(InReady), 32'd1);
    chk("post_rst_result", Result, 32'd0);
    chk("post_rst_flags", 32'(flags_u()), 32'd0);

    // Vector table
    foreach (vecs[i]) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].sel, lat);
      chk($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
      chk($sformatf("v%0d_result", i), Result, vecs[i].res);
      chk($sformatf("v%0d_result_hi", i), ResultHi, vecs[i].hi);
      chk($sformatf("v%0d_flags", i), 32'(flags_u()), 32'(vecs[i].flags));
      chk($sformatf("v%0d_signed_result", i), s_result, vecs[i].res_s);
      chk($sformatf("v%0d_inready_done", i), 32'(InReady), 32'd0);
      release_result();
      chk($sformatf("v%0d_outvalid_cleared", i), 32'(OutValid), 32'd0);
    end

    // Reset in the middle of a multiply: no result may ever surface
    OP1 = 32'hFFFFFFFF; OP2 = 32'hFFFFFFFF; Sel = 3'b011; InValid = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    InValid = 1'b0;
    repeat (5) @(negedge Clk);
    Rst_n = 1'b0;
    #1;
    chk("midrst_outvalid", 32'(OutValid), 32'd0);
    chk("midrst_inready", 32'(InReady), 32'd0);
    repeat (3) @(negedge Clk);
    Rst_n = 1'b1;
    stale = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge Clk);
      if (OutValid) stale++;
    end
    chk("midrst_no_stale_result", 32'(stale), 32'd0);
    chk("midrst_inready_after", 32'(InReady), 32'd1);
    chk("midrst_result", Result, 32'd0);
    chk("midrst_result_hi", ResultHi, 32'd0);
    chk("midrst_flags", 32'(flags_u()), 32'd0);

    // Backpressure: result held for 10 cycles while a new op waits
    run_op(32'd2, 32'd3, 3'b000, lat);
    chk("bp_result", Result, 32'd5);
    snap_r = Result; snap_h = ResultHi; snap_f = flags_u();
    OP1 = 32'd9; OP2 = 32'd9; Sel = 3'b000; InValid = 1'b1;
    unstable = 0; busy_ready = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge Clk);
      @(negedge Clk);
      if (!OutValid || Result !== snap_r || ResultHi !== snap_h || flags_u() !== snap_f) unstable++;
      if (InReady) busy_ready++;
    end
    chk("bp_outputs_stable", 32'(unstable), 32'd0);
    chk("bp_inready_low", 32'(busy_ready), 32'd0);
    OutReady = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    OutReady = 1'b0;
    chk("bp_idle_outvalid", 32'(OutValid), 32'd0);
    chk("bp_idle_inready", 32'(InReady), 32'd1);
    @(posedge Clk);
    @(negedge Clk);
    InValid = 1'b0;
    chk("bp_next_outvalid", 32'(OutValid), 32'd1);
    chk("bp_next_result", Result, 32'd18);
    release_result();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
